// File: rtl/add_digit_serial.sv
// Digit-serial adder/subtractor: processes DIGIT bits of a WIDTH-bit operation per cycle,
// with valid/ready handshakes. Define ADD_DIGIT_SERIAL_OVF_EN to add the signed-overflow output.
module add_digit_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             out_valid,
    input  logic             out_ready
`ifdef ADD_DIGIT_SERIAL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("add_digit_serial: WIDTH must be >= 1 and a multiple of DIGIT");
        end
    endgenerate

    logic [1:0]       state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT:0]   part;
    logic             last;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Select the current digit with constant slices so the mux stays a plain case decode.
    always_comb begin
        a_dig = '0;
        b_dig = '0;
        for (int j = 0; j < N; j++) begin
            if (cnt == CW'(j)) begin
                a_dig = a_reg[j*DIGIT +: DIGIT];
                b_dig = b_reg[j*DIGIT +: DIGIT];
            end
        end
    end

    assign part = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry};
    assign last = (cnt == CW'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            c_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is a + ~b + !c_in, so invert b and the carry up front.
                        a_reg <= a;
                        b_reg <= b ^ {WIDTH{sub}};
                        carry <= c_in ^ sub;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    for (int j = 0; j < N; j++) begin
                        if (cnt == CW'(j)) begin
                            sum[j*DIGIT +: DIGIT] <= part[DIGIT-1:0];
                        end
                    end
                    carry <= part[DIGIT];
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        c_out <= part[DIGIT];
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ADD_DIGIT_SERIAL_OVF_EN
    logic msb_carry_in;

    // The carry into the MSB is recovered from the MSB sum bit and its two operand bits.
    assign msb_carry_in = part[DIGIT-1] ^ a_dig[DIGIT-1] ^ b_dig[DIGIT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (state == RUN && last) begin
            ovf <= msb_carry_in ^ part[DIGIT];
        end
    end
`endif

endmodule

// File: tb/tb_add_digit_serial.sv
// Directed self-checking bench for add_digit_serial: 8/2, 2/1 (exhaustive) and 4/4 configurations.
module tb_add_digit_serial;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic       d8_in_valid = 0, d8_in_ready, d8_c_in = 0, d8_sub = 0, d8_c_out, d8_out_valid, d8_out_ready = 0, d8_ovf;
    logic [7:0] d8_a = 0, d8_b = 0, d8_sum;
    logic       d2_in_valid = 0, d2_in_ready, d2_c_in = 0, d2_sub = 0, d2_c_out, d2_out_valid, d2_out_ready = 0, d2_ovf;
    logic [1:0] d2_a = 0, d2_b = 0, d2_sum;
    logic       d4_in_valid = 0, d4_in_ready, d4_c_in = 0, d4_sub = 0, d4_c_out, d4_out_valid, d4_out_ready = 0, d4_ovf;
    logic [3:0] d4_a = 0, d4_b = 0, d4_sum;

    add_digit_serial #(.WIDTH(8), .DIGIT(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(d8_in_valid), .in_ready(d8_in_ready),
        .a(d8_a), .b(d8_b), .c_in(d8_c_in), .sub(d8_sub), .sum(d8_sum), .c_out(d8_c_out),
        .out_valid(d8_out_valid), .out_ready(d8_out_ready)
`ifdef ADD_DIGIT_SERIAL_OVF_EN
        , .ovf(d8_ovf)
`endif
    );

    add_digit_serial #(.WIDTH(2), .DIGIT(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(d2_in_valid), .in_ready(d2_in_ready),
        .a(d2_a), .b(d2_b), .c_in(d2_c_in), .sub(d2_sub), .sum(d2_sum), .c_out(d2_c_out),
        .out_valid(d2_out_valid), .out_ready(d2_out_ready)
`ifdef ADD_DIGIT_SERIAL_OVF_EN
        , .ovf(d2_ovf)
`endif
    );

    add_digit_serial #(.WIDTH(4), .DIGIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(d4_in_valid), .in_ready(d4_in_ready),
        .a(d4_a), .b(d4_b), .c_in(d4_c_in), .sub(d4_sub), .sum(d4_sum), .c_out(d4_c_out),
        .out_valid(d4_out_valid), .out_ready(d4_out_ready)
`ifdef ADD_DIGIT_SERIAL_OVF_EN
        , .ovf(d4_ovf)
`endif
    );

`ifndef ADD_DIGIT_SERIAL_OVF_EN
    assign d8_ovf = 1'b0;
    assign d2_ovf = 1'b0;
    assign d4_ovf = 1'b0;
`endif

    // sel chooses which instance the shared tasks drive and observe.
    int         sel = 0;
    logic [7:0] m_sum;
    logic       m_co, m_ov, m_valid, m_ready;

    always_comb begin
        m_sum   = d8_sum;
        m_co    = d8_c_out;
        m_ov    = d8_ovf;
        m_valid = d8_out_valid;
        m_ready = d8_in_ready;
        if (sel == 1) begin
            m_sum = {6'b0, d2_sum}; m_co = d2_c_out; m_ov = d2_ovf; m_valid = d2_out_valid; m_ready = d2_in_ready;
        end else if (sel == 2) begin
            m_sum = {4'b0, d4_sum}; m_co = d4_c_out; m_ov = d4_ovf; m_valid = d4_out_valid; m_ready = d4_in_ready;
        end
    end

    int compared = 0;
    int mismatched = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launches one operation on the selected instance; returns the number of edges until out_valid.
    task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input logic ts,
                                 output int lat);
        @(negedge clk);
        case (sel)
            0: begin d8_a = ta;      d8_b = tb;      d8_c_in = tc; d8_sub = ts; d8_in_valid = 1; end
            1: begin d2_a = ta[1:0]; d2_b = tb[1:0]; d2_c_in = tc; d2_sub = ts; d2_in_valid = 1; end
            default: begin d4_a = ta[3:0]; d4_b = tb[3:0]; d4_c_in = tc; d4_sub = ts; d4_in_valid = 1; end
        endcase
        @(posedge clk);
        @(negedge clk);
        d8_in_valid = 0; d2_in_valid = 0; d4_in_valid = 0;
        lat = 0;
        while (!m_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic releaseResult(input string tag);
        d8_out_ready = 1; d2_out_ready = 1; d4_out_ready = 1;
        @(posedge clk);
        @(negedge clk);
        d8_out_ready = 0; d2_out_ready = 0; d4_out_ready = 0;
        checkOutput({tag, "_idle_ready"}, 32'(m_ready), 32'd1);
    endtask

    typedef struct {
        int         s;
        logic [7:0] a, b;
        logic       c, sb;
        logic [7:0] es;
        logic       eco, eov;
        int         lat;
    } vec_t;

    vec_t vecs[] = '{
        '{0, 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 4},
        '{0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4},
        '{0, 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0, 4},
        '{0, 8'h20, 8'h10, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0, 4},
        '{0, 8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, 4},
        '{0, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 4},
        '{0, 8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 4},
        '{2, 8'h09, 8'h08, 1'b0, 1'b0, 8'h01, 1'b1, 1'b1, 1},
        '{2, 8'h03, 8'h04, 1'b1, 1'b0, 8'h08, 1'b0, 1'b1, 1},
        '{2, 8'h05, 8'h07, 1'b1, 1'b1, 8'h0D, 1'b0, 1'b0, 1},
        '{2, 8'h08, 8'h01, 1'b0, 1'b1, 8'h07, 1'b1, 1'b1, 1}
    };

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        #12;
        checkOutput("rst_in_ready", 32'(d8_in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(d8_out_valid), 32'd0);
        checkOutput("rst_sum", 32'(d8_sum), 32'd0);
        checkOutput("rst_c_out", 32'(d8_c_out), 32'd0);
        checkOutput("rst_ovf", 32'(d8_ovf), 32'd0);
        @(negedge clk);
        rst_n = 1;

        foreach (vecs[i]) begin
            sel = vecs[i].s;
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].sb, lat);
            checkOutput($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            checkOutput($sformatf("v%0d_sum", i), 32'(m_sum), 32'(vecs[i].es));
            checkOutput($sformatf("v%0d_c_out", i), 32'(m_co), 32'(vecs[i].eco));
`ifdef ADD_DIGIT_SERIAL_OVF_EN
            checkOutput($sformatf("v%0d_ovf", i), 32'(m_ov), 32'(vecs[i].eov));
`endif
            if (i == 0) begin
                // Hold the result while the producer keeps offering new operands.
                for (int k = 0; k < 5; k++) begin
                    d8_in_valid = 1;
                    d8_a = 8'(8'h11 * (k + 1));
                    @(posedge clk);
                    @(negedge clk);
                    checkOutput($sformatf("bp%0d_sum", k), 32'(d8_sum), 32'h96);
                    checkOutput($sformatf("bp%0d_c_out", k), 32'(d8_c_out), 32'd0);
                    checkOutput($sformatf("bp%0d_in_ready", k), 32'(d8_in_ready), 32'd0);
                    checkOutput($sformatf("bp%0d_out_valid", k), 32'(d8_out_valid), 32'd1);
                end
                d8_in_valid = 0;
            end
            releaseResult($sformatf("v%0d", i));
        end

        // Abort an operation during its second RUN cycle.
        sel = 0;
        @(negedge clk);
        d8_a = 8'h12; d8_b = 8'h34; d8_c_in = 0; d8_sub = 0; d8_in_valid = 1;
        @(posedge clk);
        @(negedge clk);
        d8_in_valid = 0;
        @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        checkOutput("abort_in_ready", 32'(d8_in_ready), 32'd1);
        checkOutput("abort_out_valid", 32'(d8_out_valid), 32'd0);
        checkOutput("abort_sum", 32'(d8_sum), 32'd0);
        checkOutput("abort_c_out", 32'(d8_c_out), 32'd0);
        @(negedge clk);
        rst_n = 1;
        applyStimulus(8'h01, 8'h01, 1'b0, 1'b0, lat);
        checkOutput("post_abort_latency", 32'(lat), 32'd4);
        checkOutput("post_abort_sum", 32'(m_sum), 32'h02);
        checkOutput("post_abort_c_out", 32'(m_co), 32'd0);
        releaseResult("post_abort");

        // Every {a,b,c_in,sub} combination on the 2-bit, 1-bit-digit instance.
        sel = 1;
        for (int code = 0; code < 64; code++) begin
            int ia, ib, ic, isub, t, sa, sb, real_res;
            logic [5:0] cv;
            cv = 6'(code);
            ia = int'(cv[5:4]); ib = int'(cv[3:2]); ic = int'(cv[1]); isub = int'(cv[0]);
            t = isub ? (ia + ((~ib) & 3) + (1 - ic)) : (ia + ib + ic);
            sa = (ia >= 2) ? ia - 4 : ia;
            sb = (ib >= 2) ? ib - 4 : ib;
            real_res = isub ? (sa - sb - ic) : (sa + sb + ic);
            applyStimulus(8'(ia), 8'(ib), cv[1], cv[0], lat);
            checkOutput($sformatf("ex%0d_latency", code), 32'(lat), 32'd2);
            checkOutput($sformatf("ex%0d_sum", code), 32'(m_sum), 32'(t & 3));
            checkOutput($sformatf("ex%0d_c_out", code), 32'(m_co), 32'((t >> 2) & 1));
`ifdef ADD_DIGIT_SERIAL_OVF_EN
            checkOutput($sformatf("ex%0d_ovf", code), 32'(m_ov), 32'((real_res > 1 || real_res < -2) ? 1 : 0));
`else
            if (real_res > 100) $display("[TB] unexpected model value %0d", real_res);
`endif
            releaseResult($sformatf("ex%0d", code));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/add_digit_serial.md
# add_digit_serial

- Parametrised, clocked successor to the combinational ripple adders in the adders library.
- Adds or subtracts two WIDTH-bit operands DIGIT bits per cycle.
- Keeps the carry in a register between digits and uses valid/ready handshakes on both sides.
- Sits wherever an area-cheap wide adder is needed and multi-cycle latency is acceptable.

## Interface
Parameters:
- WIDTH, 8: operand and result width; must be ≥1.
- DIGIT, 2: bits added per cycle; WIDTH % DIGIT == 0 (elaboration error otherwise); N = WIDTH/DIGIT.

Ports:
- clk  in  1  sole clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operands/mode present
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- c_in  in  1  carry-in (borrow-in when sub=1)
- sub  in  1  0: a+b+c_in; 1: a-b-c_in
- sum  out  WIDTH  result, valid while out_valid
- c_out  out  1  final raw carry (sub=1: 1 = no borrow)
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts result
- ovf  out  1  signed overflow (only with OVF macro, see Configuration)

## Operation
- FSM states IDLE, RUN, DONE; reset state IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch a, b^{WIDTH{sub}}, carry=c_in^sub; clear digit counter; go to RUN.
- RUN:
  - Each cycle, add digit i (bits i*DIGIT+DIGIT-1 : i*DIGIT) of the latched operands plus carry.
  - Write the DIGIT-bit result into sum at the same slice; update carry from bit DIGIT of the (DIGIT+1)-bit partial sum.
  - After digit N-1 is processed, go to DONE.
- DONE:
  - out_valid=1; sum/c_out/ovf held stable.
  - On out_valid&out_ready, go to IDLE.
- Arithmetic:
  - {c_out,sum} == a + b + c_in (mod 2^(WIDTH+1)) for sub=0.
  - For sub=1: sum == (a - b - c_in) mod 2^WIDTH, c_out == carry of a + ~b + !c_in.
- in_ready is a combinational decode of state==IDLE. in_valid, a, b, c_in and sub are ignored outside IDLE.
- sum is partially updated during RUN. Consumers sample it only when out_valid=1.

## Timing
- Reset values (asynchronous, immediate on rst_n=0): state IDLE, sum=0, c_out=0, ovf=0, out_valid=0, in_ready=1, carry=0, counter=0.
- Latency:
  - Acceptance at edge E.
  - Digits are processed at edges E+1..E+N.
  - out_valid=1 from just after edge E+N.
- Throughput: one operation per N+2 cycles with out_ready tied high. The DONE→IDLE edge and the next accept edge are distinct.
- Backpressure: out_valid stays high and outputs hold indefinitely while out_ready=0.
- out_ready asserted outside DONE has no effect.
- Boundary cases:
  - DIGIT==WIDTH (N=1): RUN lasts exactly one cycle.
  - Counter wraps only via the reset to 0 on accept.
  - The counter width is clog2(N) with a minimum of 1 bit.
- Reset mid-RUN or mid-DONE aborts the operation: the result is discarded and out_valid drops immediately.

## Configuration
- Macro ADD_DIGIT_SERIAL_OVF_EN controls the signed-overflow output.
- Defined:
  - ovf port exists.
  - ovf = carry into MSB XOR carry out of MSB, computed on the final digit.
  - ovf is registered with c_out, valid in DONE, reset 0.
- Undefined: ovf port and its logic are absent; all other behaviour is identical.

## Test plan
- WIDTH=8, DIGIT=2, sub=0, a=0x5A, b=0x3C, c_in=0:
  - sum=0x96, c_out=0, ovf=1.
  - out_valid rises 4 cycles after the accept edge.
- WIDTH=8, DIGIT=2, a=0xFF, b=0x01, c_in=0 -> sum=0x00, c_out=1, ovf=0.
- Subtraction:
  - sub=1, a=0x10, b=0x20, c_in=0 -> sum=0xF0, c_out=0.
  - sub=1, a=0x20, b=0x10, c_in=1 -> sum=0x0F, c_out=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE while toggling in_valid and a.
  - Required: sum/c_out stable, in_ready=0, no new accept.
  - The next accept occurs only after out_ready.
- Reset mid-operation:
  - Assert rst_n=0 during the 2nd RUN cycle.
  - Required: outputs return to reset values asynchronously and in_ready=1.
  - After release, a fresh operation (0x01+0x01) yields 0x02.
- Exhaustive:
  - WIDTH=2, DIGIT=1, all 64 {a,b,c_in,sub} combinations, checked against a reference model.
  - Also run WIDTH=4, DIGIT=4: latency 1, all results correct.
